// File: rtl/seven_seg_scroller.sv
// rtl/seven_seg_scroller.sv - message buffer and scrolling window for an 8-digit seven-segment display
// Characters are raw abcdefgh patterns; the window walks over message + w_digit blanks.
module seven_seg_scroller #(
    parameter int clk_mhz    = 50,
    parameter int w_digit    = 8,
    parameter int depth      = 16,
    parameter int scroll_div = 4194304
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [7:0]                 wr_data,
    input  logic                       wr_last,
    input  logic                       scroll_en,
    output logic [w_digit*8-1:0]       segments,
    output logic [$clog2(depth+1)-1:0] msg_len,
    output logic                       scroll_tick
);

    localparam int AW = $clog2(depth+1);
    localparam int IW = $clog2(depth+2*w_digit);
    localparam int TW = $clog2(scroll_div);
    localparam int BW = (depth > 1) ? $clog2(depth) : 1;

    generate
        if (depth < 1 || scroll_div < 2 || w_digit < 1 || clk_mhz < 1) begin : g_param_check
            $error("seven_seg_scroller: illegal parameter value");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        wptr_q, wptr_d;
    logic [AW-1:0]        len_q, len_d;
    logic [IW-1:0]        pos_q, pos_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [w_digit*8-1:0] seg_q, seg_d;
    logic                 tick_q, tick_d;
    logic [7:0]           buf_q [depth];

    logic [w_digit*8-1:0] window;
    logic [IW-1:0]        span;
    logic                 accept;
    logic                 last_beat;

    assign wr_ready    = (state_q != SHOW);
    assign segments    = seg_q;
    assign msg_len     = len_q;
    assign scroll_tick = tick_q;

    // clear wins over a write beat even though wr_ready was high
    assign accept    = wr_valid && wr_ready && !clear;
    assign last_beat = wr_last || (wptr_q == AW'(depth-1));
    assign span      = IW'(len_q) + IW'(w_digit);

    always_comb begin
        logic [IW-1:0] idx;
        idx    = '0;
        window = '0;
        for (int i = 0; i < w_digit; i++) begin
            idx = pos_q + IW'(i);
            if (idx >= span) begin
                idx = idx - span;
            end
            if (idx < IW'(len_q)) begin
                window[(w_digit-1-i)*8 +: 8] = buf_q[idx[BW-1:0]];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        len_d   = len_q;
        pos_d   = pos_q;
        timer_d = timer_q;
        tick_d  = 1'b0;
        seg_d   = (state_q == SHOW) ? window : '0;
        if (clear) begin
            state_d = IDLE;
            wptr_d  = '0;
            len_d   = '0;
            pos_d   = '0;
            timer_d = '0;
            seg_d   = '0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (accept) begin
                        wptr_d = wptr_q + AW'(1);
                        len_d  = wptr_q + AW'(1);
                        if (last_beat) begin
                            state_d = SHOW;
                            pos_d   = '0;
                            timer_d = '0;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
                SHOW: begin
                    if (scroll_en) begin
                        if (timer_q == TW'(scroll_div-1)) begin
                            timer_d = '0;
                            tick_d  = 1'b1;
                            pos_d   = (pos_q == span - IW'(1)) ? '0 : pos_q + IW'(1);
                        end else begin
                            timer_d = timer_q + TW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            len_q   <= '0;
            pos_q   <= '0;
            timer_q <= '0;
            seg_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            len_q   <= len_d;
            pos_q   <= pos_d;
            timer_q <= timer_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    // Buffer is not reset: a zero msg_len masks stale characters.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[wptr_q[BW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_seven_seg_scroller.sv
// tb/tb_seven_seg_scroller.sv - directed self-checking bench for seven_seg_scroller
module tb_seven_seg_scroller;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        wr_last;
    logic        scroll_en;
    logic [63:0] segments;
    logic [4:0]  msg_len;
    logic        scroll_tick;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] WIN0 = 64'hEE9EFC0000000000;

    seven_seg_scroller #(
        .clk_mhz(50),
        .w_digit(8),
        .depth(16),
        .scroll_div(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clear(clear),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .wr_last(wr_last),
        .scroll_en(scroll_en),
        .segments(segments),
        .msg_len(msg_len),
        .scroll_tick(scroll_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = 8'h00;
        wr_last   = 1'b0;
        scroll_en = 1'b0;
        #2;
        chk("rst_segments", segments, 64'h0);
        chk("rst_msg_len", 64'(msg_len), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_tick", 64'(scroll_tick), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_segments", segments, 64'h0);
        chk("post_rst_msg_len", 64'(msg_len), 64'd0);
        chk("post_rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("post_rst_tick", 64'(scroll_tick), 64'd0);

        // load three characters, last on the third
        wr_valid = 1'b1; wr_data = 8'hEE; wr_last = 1'b0;
        step();
        chk("load1_msg_len", 64'(msg_len), 64'd1);
        chk("load1_wr_ready", 64'(wr_ready), 64'd1);
        wr_data = 8'h9E;
        step();
        wr_data = 8'hFC; wr_last = 1'b1;
        step();
        chk("load3_msg_len", 64'(msg_len), 64'd3);
        chk("load3_wr_ready", 64'(wr_ready), 64'd0);
        chk("load3_segments_still_zero", segments, 64'h0);
        wr_valid = 1'b0; wr_last = 1'b0;
        scroll_en = 1'b1;

        // scroll: tick every 4th edge, window follows one edge later
        for (int c = 1; c <= 45; c++) begin
            step();
            chk($sformatf("tick_c%0d", c), 64'(scroll_tick), 64'((c % 4) == 0));
            if (c == 1)  chk("win_pos0", segments, WIN0);
            if (c == 5)  chk("win_pos1", segments, 64'h9EFC000000000000);
            if (c == 9)  chk("win_pos2", segments, 64'hFC00000000000000);
            if (c == 13) chk("win_pos3_blank", segments, 64'h0);
            if (c == 33) chk("win_pos8", segments, 64'h000000EE9EFC0000);
            if (c == 41) chk("win_pos10", segments, 64'h00EE9EFC00000000);
            if (c == 45) chk("win_wrap_pos0", segments, WIN0);
        end

        // freeze mid-count: timer is at 2 after this edge
        step();
        chk("pre_freeze_tick", 64'(scroll_tick), 64'd0);
        scroll_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("freeze_tick_%0d", c), 64'(scroll_tick), 64'd0);
            chk($sformatf("freeze_seg_%0d", c), segments, WIN0);
        end
        scroll_en = 1'b1;
        step();
        chk("resume_tick_a", 64'(scroll_tick), 64'd0);
        step();
        chk("resume_tick_b", 64'(scroll_tick), 64'd1);
        step();
        chk("resume_win_pos1", segments, 64'h9EFC000000000000);

        // overflow: 16 beats without wr_last
        clear = 1'b1; scroll_en = 1'b0;
        step();
        chk("clear_msg_len", 64'(msg_len), 64'd0);
        chk("clear_wr_ready", 64'(wr_ready), 64'd1);
        chk("clear_segments", segments, 64'h0);
        clear = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i + 1);
            chk($sformatf("ovf_ready_%0d", i), 64'(wr_ready), 64'd1);
            step();
        end
        chk("ovf_msg_len", 64'(msg_len), 64'd16);
        chk("ovf_wr_ready", 64'(wr_ready), 64'd0);
        wr_data = 8'hAA;
        step();
        chk("ovf_17th_msg_len", 64'(msg_len), 64'd16);
        chk("ovf_17th_wr_ready", 64'(wr_ready), 64'd0);
        chk("ovf_window", segments, 64'h0102030405060708);
        wr_valid = 1'b0;

        // clear colliding with an accepted beat in LOAD
        clear = 1'b1;
        step();
        clear = 1'b0;
        wr_valid = 1'b1; wr_data = 8'h11; wr_last = 1'b0;
        step();
        chk("coll_load_msg_len", 64'(msg_len), 64'd1);
        wr_data = 8'h22; clear = 1'b1;
        step();
        chk("coll_msg_len", 64'(msg_len), 64'd0);
        chk("coll_wr_ready", 64'(wr_ready), 64'd1);
        clear = 1'b0; wr_valid = 1'b0;
        step();
        chk("coll_idle_msg_len", 64'(msg_len), 64'd0);
        wr_valid = 1'b1; wr_data = 8'h33; wr_last = 1'b1;
        step();
        chk("reload_msg_len", 64'(msg_len), 64'd1);
        wr_valid = 1'b0; wr_last = 1'b0;
        step();
        chk("reload_window", segments, 64'h3300000000000000);

        // asynchronous reset in SHOW
        rst_n = 1'b0;
        #1;
        chk("async_rst_segments", segments, 64'h0);
        chk("async_rst_msg_len", 64'(msg_len), 64'd0);
        chk("async_rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("async_rst_tick", 64'(scroll_tick), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scroller.md
Name: seven_seg_scroller

Overview:
- Upstream stage of the 8-digit seven-segment word display.
- Accepts a message of raw segment patterns (abcdefgh encoding, h = LSB) over a valid/ready write port and stores up to `depth` characters.
- Scrolls the message across a `w_digit`-wide window at a fixed step rate, with blank padding so the text scrolls fully in and out.
- Presents the window as a flat bus of per-digit patterns, consumed by the display multiplexer, which drives `abcdefgh` and `digit`.

Parameters:
- clk_mhz, 50: clock frequency in MHz; informational only, no logic depends on it.
- w_digit, 8: number of display digits (window width).
- depth, 16: maximum message length in characters; must be ≥ 1.
- scroll_div, 4194304: clock cycles per scroll step; must be ≥ 2.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- clear, input, 1: synchronous flush back to empty.
- wr_valid, input, 1: write beat valid.
- wr_ready, output, 1: block can accept a beat.
- wr_data, input, 8: segment pattern of one character.
- wr_last, input, 1: final character of the message.
- scroll_en, input, 1: scrolling enabled; when low, the window freezes.
- segments, output, w_digit*8: window patterns; bits [w_digit*8-1 -: 8] are the leftmost digit.
- msg_len, output, $clog2(depth+1): number of stored characters.
- scroll_tick, output, 1: one-cycle pulse on each scroll step.

Behaviour:
- Clock and reset: single clock `clk`. Reset is asynchronous, active-low (`rst_n`); it is asserted asynchronously and released synchronously to `clk` upstream.
- State machine states: IDLE, LOAD, SHOW.
- Reset values: state = IDLE, write pointer = 0, msg_len = 0, pos = 0, step timer = 0, segments = 0, scroll_tick = 0.
- wr_ready: equals (state != SHOW), decoded directly from the state register. It is therefore 1 immediately after reset.
- Write acceptance: a beat is accepted when wr_valid && wr_ready.
  - Store wr_data at buffer[wptr].
  - Update wptr <= wptr + 1 and msg_len <= wptr + 1.
- IDLE -> LOAD: on an accepted beat with wr_last = 0.
- IDLE -> SHOW or LOAD -> SHOW: on an accepted beat with wr_last = 1, or on an accepted beat at wptr = depth-1 (overflow forces last). In both cases pos <= 0 and the timer <= 0.
- LOAD stays in LOAD while accepted beats are not last. Idle cycles (wr_valid = 0) are allowed.
- SHOW ignores wr_valid, since wr_ready = 0. A new message is only loaded after `clear`.
- clear:
  - Takes effect on the next edge from any state: state = IDLE, wptr = 0, msg_len = 0, pos = 0, timer = 0, segments = 0.
  - Has priority over a simultaneous write beat and over a scroll step. That beat is not stored, although wr_ready was 1.
- Virtual sequence: length L + w_digit, where L = msg_len.
  - Index k < L is buffer[k].
  - Index k ≥ L is blank (8'h00).
- Window: digit i (i = 0 is leftmost) shows virtual[(pos + i) mod (L + w_digit)].
  - The modulo is computed with a compare-and-subtract; no divider.
  - pos = 0 therefore shows the first w_digit characters.
- Step timer:
  - Runs only in SHOW with scroll_en = 1.
  - Counts 0 .. scroll_div-1. At the terminal count it wraps to 0 and issues a step.
  - scroll_en = 0 holds both the timer and pos.
- Scroll step:
  - scroll_tick = 1 for exactly that cycle.
  - pos <= (pos == L + w_digit - 1) ? 0 : pos + 1, so the message wraps around.
- segments latency:
  - Registered, one cycle after state or pos changes.
  - All zero in IDLE and LOAD.
  - Valid from the first cycle after entering SHOW plus one.
- Reset mid-operation: all state is discarded immediately, asynchronously. Buffer contents need not be reset, since msg_len = 0 masks them.

Test Plan:
- Reset state: rst_n = 0 -> segments = 0, msg_len = 0, wr_ready = 1, scroll_tick = 0. Release reset -> values are unchanged.
- Load and display (depth 16, w_digit 8): write 8'hEE, 8'h9E, 8'hFC with wr_last on the third beat -> msg_len = 3, wr_ready = 0. One cycle later segments = {EE, 9E, FC, 00, 00, 00, 00, 00}.
- Scroll and wrap (scroll_div = 4): with the message from the previous scenario, hold scroll_en = 1.
  - scroll_tick pulses every 4 cycles.
  - After 1 step the leftmost digit = 9E.
  - After 3 steps segments = 0.
  - After 11 steps (L + w_digit) pos = 0 and segments equal the initial window.
- Freeze: drop scroll_en mid-count for 10 cycles -> no scroll_tick and segments unchanged. Re-raise -> the next tick arrives after the remaining count, not a fresh 4.
- Overflow: 16 beats, none with wr_last -> SHOW after the 16th beat, msg_len = 16. A 17th wr_valid is not accepted (wr_ready = 0).
- Clear collision: in LOAD, assert clear together with an accepted beat -> IDLE, msg_len = 0, beat dropped. Assert rst_n = 0 mid-SHOW -> outputs go to 0 immediately, without waiting for a clock edge.
